// File: rtl/bcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_pkg : shared BCD digit types and the per-digit subtract cell |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package bcd_pkg;

  localparam int c_DIGIT_W = 4;

  typedef logic [c_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    logic       g;   // digit difference is negative: borrow generated
    logic       p;   // digit difference is zero: incoming borrow passes through
    bcd_digit_t r0;  // result digit when no borrow arrives from below
    bcd_digit_t r1;  // result digit when a borrow arrives from below
  } digit_sub_t;

  function automatic digit_sub_t digit_sub(input bcd_digit_t a_i, input bcd_digit_t b_i);
    logic signed [5:0] d;
    digit_sub_t        res;
    d      = $signed({2'b00, a_i}) - $signed({2'b00, b_i});
    res.g  = d[5];
    res.p  = (d == 6'sd0);
    // Low nibble arithmetic is mod 16, so adding 10 (or 9) folds negatives into 0..9.
    res.r0 = res.g ? (d[3:0] + 4'd10) : d[3:0];
    res.r1 = (res.g | res.p) ? (d[3:0] + 4'd9) : (d[3:0] - 4'd1);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_borrow_prefix.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_borrow_prefix : Kogge-Stone borrow lookahead over N digits   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bcd_borrow_prefix #(
  parameter int N = 34
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  output logic [N:0]   borrow
);

  localparam int c_LEVELS = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] w_g [c_LEVELS+1];
  logic [N-1:0] w_p [c_LEVELS+1];

  // After level l, bit i holds the group generate/propagate of digits [i-2^(l+1)+1 .. i].
  always_comb begin
    w_g[0] = g;
    w_p[0] = p;
    for (int l = 0; l < c_LEVELS; l++) begin
      w_g[l+1] = w_g[l];
      w_p[l+1] = w_p[l];
      for (int i = (1 << l); i < N; i++) begin
        w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i - (1 << l)]);
        w_p[l+1][i] = w_p[l][i] & w_p[l][i - (1 << l)];
      end
    end
  end

  assign borrow = {w_g[c_LEVELS], 1'b0};

endmodule
`default_nettype wire

// File: rtl/bcd_subtract.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_subtract : 2-stage pipelined N-digit packed-BCD a - b        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bcd_subtract
  import bcd_pkg::*;
#(
  parameter int N = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [c_DIGIT_W*N-1:0] a,
  input  logic [c_DIGIT_W*N-1:0] b,
  output logic [c_DIGIT_W*N-1:0] o,
  output logic                 sgn
);

  localparam int c_W = c_DIGIT_W * N;

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_borrow;
  logic [c_W-1:0] w_o_next;

  for (genvar i = 0; i < N; i++) begin : g_digit
    digit_sub_t r_s1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_s1 <= '0;
      else        r_s1 <= digit_sub(a[c_DIGIT_W*i +: c_DIGIT_W], b[c_DIGIT_W*i +: c_DIGIT_W]);
    end

    assign w_g[i] = r_s1.g;
    assign w_p[i] = r_s1.p;
    assign w_o_next[c_DIGIT_W*i +: c_DIGIT_W] = w_borrow[i] ? r_s1.r1 : r_s1.r0;
  end

  bcd_borrow_prefix #(
    .N (N)
  ) u_prefix (
    .g      (w_g),
    .p      (w_p),
    .borrow (w_borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o   <= '0;
      sgn <= 1'b0;
    end else begin
      o   <= w_o_next;
      sgn <= w_borrow[N];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_subtract.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bcd_subtract : scoreboard bench for the pipelined BCD subtract|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bcd_subtract;

  localparam int N = 34;
  localparam int W = 4 * N;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] o;
  logic         sgn;

  bcd_subtract #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .o     (o),
    .sgn   (sgn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] o;
    logic         sgn;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Tracks which cycles carry a result the bench issued (two-edge latency).
  logic in_v = 1'b0;
  logic v1   = 1'b0;
  logic v2   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= in_v;
      v2 <= v1;
    end
  end

  task automatic check(input string name, input logic [W-1:0] got_o, input logic got_s,
                       input logic [W-1:0] exp_o, input logic exp_s);
    n_cmp++;
    if (got_o !== exp_o || got_s !== exp_s) begin
      n_bad++;
      $display("FAIL %s: got o=%h sgn=%b, expected o=%h sgn=%b", name, got_o, got_s, exp_o, exp_s);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && v2) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got o=%h sgn=%b, expected no output", o, sgn);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, o, sgn, e.o, e.sgn);
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eo, input logic es, input string name);
    @(negedge clk);
    a    = av;
    b    = bv;
    in_v = 1'b1;
    sb.push_back('{eo, es, name});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_v = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Digit-serial decimal reference: schoolbook subtraction with borrow.
  function automatic void ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] ro, output logic rs);
    int bw;
    bw = 0;
    ro = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(av[4*i +: 4]) - int'(bv[4*i +: 4]) - bw;
      if (d < 0) begin
        d  = d + 10;
        bw = 1;
      end else begin
        bw = 0;
      end
      ro[4*i +: 4] = d[3:0];
    end
    rs = bw[0];
  endfunction

  initial begin
    logic [W-1:0] nines;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] eo;
    logic         es;
    nines = {N{4'h9}};

    #1 rst_n = 1'b0;
    #1 check("reset_state", o, sgn, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue({8'h50, {(N-2){4'h0}}}, {8'h50, {(N-2){4'h0}}}, '0, 1'b0, "equal_ops");
    issue(W'(1), W'(2), nines, 1'b1, "one_minus_two");
    issue(W'('h1000), W'(1), W'('h0999), 1'b0, "long_borrow");
    issue('0, nines, W'(1), 1'b1, "zero_minus_max");
    issue(W'(5), W'(3), W'(2), 1'b0, "stream_0");
    issue(W'(3), W'(5), {{(N-1){4'h9}}, 4'h8}, 1'b1, "stream_1");
    issue(W'('h99), W'('h99), '0, 1'b0, "stream_2");
    idle(3);

    // Reset lands while two results are still in the pipeline.
    issue(W'(5), W'(3), W'(2), 1'b0, "pre_reset_0");
    issue(W'(7), W'(1), W'(6), 1'b0, "pre_reset_1");
    issue(W'(9), W'(8), W'(1), 1'b0, "pre_reset_2");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_v  = 1'b0;
    sb.delete();
    #1 check("async_reset", o, sgn, '0, 1'b0);
    a = W'(9);
    b = '0;
    repeat (2) @(negedge clk);
    check("held_in_reset", o, sgn, '0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    a     = W'('h42);
    b     = W'('h17);
    in_v  = 1'b1;
    sb.push_back('{W'('h25), 1'b0, "first_after_reset"});
    @(posedge clk);
    #1 check("no_stale_after_reset", o, sgn, '0, 1'b0);

    issue('0, '0, '0, 1'b0, "zero_zero");
    issue(nines, nines, '0, 1'b0, "max_max");
    issue(nines, '0, nines, 1'b0, "max_minus_zero");
    for (int k = 0; k < 10000; k++) begin
      ra = rand_bcd();
      rb = (k % 50 == 0) ? ra : rand_bcd();
      ref_sub(ra, rb, eo, es);
      issue(ra, rb, eo, es, "random");
    end
    idle(4);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
